// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared constants for the sequential restoring divider:
//             state encoding, default operand widths, divide-by-zero quotient.
//  Revision : 1.0  initial release
// ============================================================================
package div_pkg;

    // Controller state encoding (one bit is enough for IDLE/RUN)
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Default operand widths
    localparam int DIV_DW = 8;
    localparam int DIV_VW = 4;

    // Quotient reported on divide-by-zero at the default width (all ones)
    localparam logic [DIV_DW-1:0] DIV_DBZ_Q = '1;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-division step. Shifts the next
//             dividend bit into the partial remainder, compares against the
//             divisor and conditionally subtracts, yielding one quotient bit.
//  Revision : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] i_r,      // partial remainder, always < divisor
    input  logic          i_q_msb,  // next dividend bit shifted in
    input  logic [VW-1:0] i_d,      // divisor
    output logic [VW-1:0] o_r,      // next partial remainder, < divisor
    output logic          o_q_bit   // quotient bit for this step
);

    logic [VW:0] w_shift;
    logic        w_ge;

    // Shift, compare in VW+1 bits, and restore (skip the subtract) when short.
    // The difference is always below the divisor, so its low VW bits are exact.
    always_comb begin
        w_shift = {i_r, i_q_msb};
        w_ge    = (w_shift >= {1'b0, i_d});
        o_q_bit = w_ge;
        o_r     = w_ge ? (w_shift[VW-1:0] - i_d) : w_shift[VW-1:0];
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_8x4_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_8x4_seq
//  Purpose  : Sequential restoring divider, DW-bit dividend by VW-bit divisor,
//             one quotient bit per clock, start/busy/done handshake with a
//             single-cycle divide-by-zero shortcut. Requires VW <= DW.
//  Revision : 1.0  initial release
// ============================================================================
module div_8x4_seq
    import div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          dbz
);

    localparam int CW = $clog2(DW + 1);

    logic          r_state;
    logic [DW-1:0] r_q;      // dividend shifting out / quotient shifting in
    logic [VW-1:0] r_d;      // latched divisor
    logic [VW-1:0] r_r;      // partial remainder; its extra top bit is always
                             // zero between steps, so only VW bits are kept
    logic [CW-1:0] r_cnt;    // steps still to perform

    logic [VW-1:0] w_r_next;
    logic          w_q_bit;

    div_step #(
        .VW (VW)
    ) u_step (
        .i_r     (r_r),
        .i_q_msb (r_q[DW-1]),
        .i_d     (r_d),
        .o_r     (w_r_next),
        .o_q_bit (w_q_bit)
    );

    // Controller: accept operands in IDLE, iterate DW steps in RUN, publish results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_q       <= '0;
            r_d       <= '0;
            r_r       <= '0;
            r_cnt     <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dbz       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            r_q     <= dividend;
                            r_d     <= divisor;
                            r_r     <= '0;
                            r_cnt   <= CW'(DW);
                            busy    <= 1'b1;
                            dbz     <= 1'b0;
                            r_state <= ST_RUN;
                        end else begin
                            // Divide-by-zero resolves immediately without iterating
                            quotient  <= {DW{1'b1}};
                            remainder <= dividend[VW-1:0];
                            dbz       <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_q   <= {r_q[DW-2:0], w_q_bit};
                    r_r   <= w_r_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        quotient  <= {r_q[DW-2:0], w_q_bit};
                        remainder <= w_r_next;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : div_8x4_seq
`default_nettype wire

// File: tb/tb_div_8x4_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_8x4_seq
//  Purpose  : Self-checking bench for div_8x4_seq with directed vectors and an
//             exhaustive sweep over nonzero divisors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_8x4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;

    int n_checks = 0;
    int n_fail   = 0;

    div_8x4_seq #(
        .DW (8),
        .VW (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) until done is seen at a falling edge; returns edges since start edge
    task automatic wait_done(input int inj_at, output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == inj_at) begin
                start = 1'b1; dividend = 8'd9; divisor = 4'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    // Issues one operation and checks busy, latency and results
    task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] eq, input logic [3:0] er, input int inj_at);
        int cyc;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = 8'($urandom); divisor = 4'($urandom);
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        wait_done(inj_at, cyc);
        chk({tag, " latency"}, cyc, 32'd8);
        chk({tag, " quotient"}, {24'd0, quotient}, {24'd0, eq});
        chk({tag, " remainder"}, {28'd0, remainder}, {28'd0, er});
        chk({tag, " dbz"}, {31'd0, dbz}, 32'd0);
        chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        int q, r;

        // Reset with start held high: reset must win
        rst_n = 1'b0; start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst quotient", {24'd0, quotient}, 32'd0);
        chk("rst remainder", {28'd0, remainder}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst dbz", {31'd0, dbz}, 32'd0);
        rst_n = 1'b1; start = 1'b0;

        run_div("200/7", 8'd200, 4'd7, 8'd28, 4'd4, 0);
        @(negedge clk);
        chk("200/7 done pulse", {31'd0, done}, 32'd0);
        chk("200/7 held q", {24'd0, quotient}, 32'd28);

        run_div("255/15", 8'd255, 4'd15, 8'd17, 4'd0, 0);
        run_div("255/1", 8'd255, 4'd1, 8'd255, 4'd0, 0);
        run_div("5/9", 8'd5, 4'd9, 8'd0, 4'd5, 0);

        // Divide by zero
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("dbz done", {31'd0, done}, 32'd1);
        chk("dbz busy", {31'd0, busy}, 32'd0);
        chk("dbz quotient", {24'd0, quotient}, 32'd255);
        chk("dbz remainder", {28'd0, remainder}, 32'd4);
        chk("dbz flag", {31'd0, dbz}, 32'd1);
        @(negedge clk);
        chk("dbz done pulse", {31'd0, done}, 32'd0);
        chk("dbz busy after", {31'd0, busy}, 32'd0);
        chk("dbz flag held", {31'd0, dbz}, 32'd1);

        // Start during busy is ignored
        run_div("150/11 ign", 8'd150, 4'd11, 8'd13, 4'd7, 3);

        // Back-to-back: start issued in the done cycle
        start = 1'b1; dividend = 8'd60; divisor = 4'd4;
        @(negedge clk);
        start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        chk("b2b done drop", {31'd0, done}, 32'd0);
        chk("b2b busy", {31'd0, busy}, 32'd1);
        wait_done(0, cyc);
        chk("b2b latency", cyc, 32'd8);
        chk("b2b quotient", {24'd0, quotient}, 32'd15);
        chk("b2b remainder", {28'd0, remainder}, 32'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);
        chk("midrst quotient", {24'd0, quotient}, 32'd0);
        chk("midrst remainder", {28'd0, remainder}, 32'd0);
        repeat (10) @(negedge clk);
        chk("midrst no done", {31'd0, done}, 32'd0);
        run_div("12/5", 8'd12, 4'd5, 8'd2, 4'd2, 0);

        // Exhaustive sweep against the arithmetic reference
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                q = a / b;
                r = a % b;
                run_div("sweep", 8'(a), 4'(b), 8'(q), 4'(r), 0);
                chk("sweep identity", quotient * b + remainder, a);
                chk("sweep r<d", {31'd0, (remainder < 4'(b))}, 32'd1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_8x4_seq
`default_nettype wire
